fd_stage: RTL and testbench

FD_STAGE -- requirements
Module: fd_stage

---
 rtl/fd_stage_pkg.sv | 36 +++
 rtl/fd_stage_d_npc.sv | 32 +++
 rtl/fd_stage.sv | 50 +++++
 tb/tb_fd_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fd_stage_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, reset PC and the
// control-flow classification used by the decode-stage next-PC logic.
package fd_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_REG    = 2'd3
  } npc_sel_e;

  // Pick the next-PC source for a decode instruction; eq is rs==rt.
  function automatic npc_sel_e classify(input logic [31:0] instr, input logic eq);
    npc_sel_e sel;
    sel = NPC_SEQ;
    case (instr[31:26])
      OP_BEQ:     sel = eq ? NPC_BRANCH : NPC_SEQ;
      OP_BNE:     sel = eq ? NPC_SEQ : NPC_BRANCH;
      OP_J,
      OP_JAL:     sel = NPC_JUMP;
      OP_SPECIAL: sel = (instr[5:0] == FUNCT_JR) ? NPC_REG : NPC_SEQ;
      default:    sel = NPC_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fd_stage_d_npc.sv
// Purely combinational next-PC selection for the instruction in decode.
// Non-taken branches fall through to f_PC+4 so the delay slot in fetch
// is always kept.
module d_npc
  import fd_stage_pkg::*;
(
  input  logic [31:0] d_PC,
  input  logic [31:0] d_Instr,
  input  logic [31:0] f_PC,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  output logic [31:0] npc
);

  logic [31:0] br_off;
  npc_sel_e    sel;

  assign br_off = {{14{d_Instr[15]}}, d_Instr[15:0], 2'b00};
  assign sel    = classify(d_Instr, d_rs_data == d_rt_data);

  // Select the next PC; all additions wrap modulo 2^32.
  always_comb begin
    npc = f_PC + 32'd4;
    case (sel)
      NPC_BRANCH: npc = d_PC + 32'd4 + br_off;
      NPC_JUMP:   npc = {d_PC[31:28], d_Instr[25:0], 2'b00};
      NPC_REG:    npc = d_rs_data;
      default:    npc = f_PC + 32'd4;
    endcase
  end

endmodule

// File: rtl/fd_stage.sv
// Fetch/decode pipeline register plus glue: holds on stall, resets to a
// nop at RESET_PC, and exposes next-PC, fetch enable and jal link value.
module fd_stage
  import fd_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_PC,
  input  logic [31:0] f_Instr,
  input  logic        stall,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  output logic [31:0] d_PC,
  output logic [31:0] d_Instr,
  output logic [31:0] d_NPC,
  output logic        PC_en,
  output logic [31:0] d_link
);

  logic [31:0] pc_reg;
  logic [31:0] instr_reg;

  // F/D register: async clear to a nop at RESET_PC, capture when not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
    end else if (!stall) begin
      pc_reg    <= f_PC;
      instr_reg <= f_Instr;
    end
  end

  assign d_PC    = pc_reg;
  assign d_Instr = instr_reg;
  assign PC_en   = ~stall;
  assign d_link  = pc_reg + 32'd8;

  d_npc u_npc (
    .d_PC      (pc_reg),
    .d_Instr   (instr_reg),
    .f_PC      (f_PC),
    .d_rs_data (d_rs_data),
    .d_rt_data (d_rt_data),
    .npc       (d_NPC)
  );

endmodule

// File: tb/tb_fd_stage.sv
// Directed bench for fd_stage: reset, branches, jumps, stall, wrap-around
// and reset during a stall, with hand-computed expected values.
module tb_fd_stage;

  logic        clk;
  logic        reset;
  logic [31:0] f_PC;
  logic [31:0] f_Instr;
  logic        stall;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic [31:0] d_PC;
  logic [31:0] d_Instr;
  logic [31:0] d_NPC;
  logic        PC_en;
  logic [31:0] d_link;

  int checks = 0;
  int errors = 0;

  fd_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_PC      (f_PC),
    .f_Instr   (f_Instr),
    .stall     (stall),
    .d_rs_data (d_rs_data),
    .d_rt_data (d_rt_data),
    .d_PC      (d_PC),
    .d_Instr   (d_Instr),
    .d_NPC     (d_NPC),
    .PC_en     (PC_en),
    .d_link    (d_link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    f_PC      = 32'h0000_3000;
    f_Instr   = 32'h1234_5678;
    d_rs_data = 32'h0;
    d_rt_data = 32'h0;

    // Reset held across edges
    #12;
    check("rst_d_PC",    d_PC,    32'h0000_3000);
    check("rst_d_Instr", d_Instr, 32'h0);
    check("rst_d_NPC",   d_NPC,   32'h0000_3004);
    check("rst_PC_en",   {31'h0, PC_en}, 32'h1);
    check("rst_d_link",  d_link,  32'h0000_3008);
    reset = 1'b1;

    // beq taken / not taken
    f_PC = 32'h0000_3004; f_Instr = 32'h1085_0003;
    d_rs_data = 32'd5; d_rt_data = 32'd5;
    tick();
    check("beq_d_PC",    d_PC,    32'h0000_3004);
    check("beq_d_Instr", d_Instr, 32'h1085_0003);
    check("beq_taken",   d_NPC,   32'h0000_3014);
    d_rt_data = 32'd6; #1;
    check("beq_not_taken", d_NPC, 32'h0000_3008);

    // bne taken / not taken
    f_PC = 32'h0000_3008; f_Instr = 32'h1485_0003;
    tick();
    check("bne_taken", d_NPC, 32'h0000_3018);
    d_rt_data = 32'd5; #1;
    check("bne_not_taken", d_NPC, 32'h0000_300C);

    // jal
    f_PC = 32'h0000_3010; f_Instr = 32'h0C00_0C10;
    tick();
    check("jal_npc",  d_NPC,  32'h0000_3040);
    check("jal_link", d_link, 32'h0000_3018);

    // j with d_PC upper nibble zero
    f_PC = 32'h0000_3014; f_Instr = 32'h0800_0C20;
    tick();
    check("j_npc", d_NPC, 32'h0000_3080);

    // jr
    f_PC = 32'h0000_3018; f_Instr = 32'h03E0_0008;
    d_rs_data = 32'h0000_3018;
    tick();
    check("jr_npc", d_NPC, 32'h0000_3018);
    d_rs_data = 32'h0000_4000; #1;
    check("jr_npc2", d_NPC, 32'h0000_4000);

    // SPECIAL non-jr (addu) is sequential
    f_PC = 32'h0000_301C; f_Instr = 32'h0085_1021;
    tick();
    check("addu_npc", d_NPC, 32'h0000_3020);

    // Stall with taken beq (offset -1) in decode
    f_PC = 32'h0000_3020; f_Instr = 32'h1085_FFFF;
    d_rs_data = 32'd7; d_rt_data = 32'd7;
    tick();
    stall = 1'b1; f_PC = 32'h0000_3024; f_Instr = 32'hAAAA_0000; #1;
    check("stall_PC_en", {31'h0, PC_en}, 32'h0);
    check("stall_npc_target", d_NPC, 32'h0000_3020);
    tick();
    f_Instr = 32'hBBBB_0000;
    tick();
    check("stall_d_PC",    d_PC,    32'h0000_3020);
    check("stall_d_Instr", d_Instr, 32'h1085_FFFF);
    stall = 1'b0; f_PC = 32'h0000_3028; f_Instr = 32'h0; #1;
    check("release_PC_en", {31'h0, PC_en}, 32'h1);
    tick();
    check("release_d_PC",    d_PC,    32'h0000_3028);
    check("release_d_Instr", d_Instr, 32'h0);
    check("nop_npc",         d_NPC,   32'h0000_302C);

    // Wrap-around
    f_PC = 32'hFFFF_FFFC; f_Instr = 32'h0; #1;
    check("wrap_npc", d_NPC, 32'h0);
    tick();
    check("wrap_link", d_link, 32'h0000_0004);

    // Reset during a stall, between edges
    stall = 1'b1; f_PC = 32'h0000_4000; f_Instr = 32'h1234_5678;
    tick();
    check("pre_rst_hold", d_PC, 32'hFFFF_FFFC);
    #3 reset = 1'b0;
    #1;
    check("midrst_d_PC",    d_PC,    32'h0000_3000);
    check("midrst_d_Instr", d_Instr, 32'h0);
    check("midrst_d_link",  d_link,  32'h0000_3008);
    #2 reset = 1'b1;
    tick();
    check("post_rst_stalled", d_PC, 32'h0000_3000);
    stall = 1'b0;
    tick();
    check("post_rst_d_PC",    d_PC,    32'h0000_4000);
    check("post_rst_d_Instr", d_Instr, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
